// File: rtl/man_tx_sched.sv
// Two-requester round-robin Manchester byte serializer. Grant is combinational in IDLE; first half-bit one tick later.
// Backpressure: requesters hold req (level) until their gnt; en low only blocks new grants, frames in flight complete.
module man_tx_sched #(
    parameter logic        IDLE_LEVEL = 1'b0,
    parameter int unsigned GAP_HALVES = 2
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       bit_tick,
    input  logic       en,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       code,
    output logic       busy,
    output logic       src,
    output logic       tx_done
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [4:0] LAST_HALF = 5'd16;
    localparam logic [3:0] GAP_LAST  = (GAP_HALVES == 0) ? 4'd0 : 4'(GAP_HALVES - 1);

    state_t      state;
    logic [15:0] shreg;
    logic [4:0]  half_cnt;
    logic [3:0]  gap_cnt;
    logic        can_grant;
    logic        pick1;
    logic [7:0]  gnt_data;

    // Each data bit becomes two half-bits: 1 -> 01, 0 -> 10, MSB first.
    function automatic logic [15:0] man_encode(input logic [7:0] b);
        logic [15:0] w;
        w = '0;
        for (int i = 7; i >= 0; i--) begin
            w = {w[13:0], ~b[i], b[i]};
        end
        return w;
    endfunction

    // On a tie the requester that was not served last wins.
    assign can_grant = rst && en && (state == IDLE) && (req0 || req1);
    assign pick1     = req1 && (!req0 || !src);
    assign gnt0      = can_grant && !pick1;
    assign gnt1      = can_grant && pick1;
    assign gnt_data  = pick1 ? data1 : data0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state    <= IDLE;
            code     <= IDLE_LEVEL;
            tx_done  <= 1'b0;
            src      <= 1'b1;
            shreg    <= '0;
            half_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    code <= IDLE_LEVEL;
                    if (can_grant) begin
                        src      <= pick1;
                        shreg    <= man_encode(gnt_data);
                        half_cnt <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (bit_tick) begin
                        if (half_cnt != LAST_HALF) begin
                            code     <= shreg[15];
                            shreg    <= {shreg[14:0], 1'b0};
                            half_cnt <= half_cnt + 5'd1;
                        end else begin
                            // The 17th tick closes the last half-bit so it is a full period wide.
                            code    <= IDLE_LEVEL;
                            tx_done <= 1'b1;
                            gap_cnt <= '0;
                            if (GAP_HALVES == 0) begin
                                state <= IDLE;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    code <= IDLE_LEVEL;
                    if (bit_tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= IDLE;
                        end else if (gap_cnt != 4'hF) begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    code  <= IDLE_LEVEL;
                end
            endcase
        end
    end

    a_one_gnt: assert property (@(posedge clk_in) disable iff (!rst) !(gnt0 && gnt1));
    a_idle_line: assert property (@(posedge clk_in) disable iff (!rst) (state != SEND) |-> (code == IDLE_LEVEL));

endmodule

// File: tb/tb_man_tx_sched.sv
// Bench for man_tx_sched: two instances (gap 2 and gap 0) against a tick-counting frame model.
module tb_man_tx_sched;

    localparam logic IDLE_LEVEL = 1'b0;
    localparam int   GH_A = 2;
    localparam int   GH_B = 0;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       bit_tick = 1'b0;
    logic [1:0] en_v = 2'b11;
    logic [1:0] req0_v = 2'b10;
    logic [1:0] req1_v = 2'b00;
    logic [7:0] data0_v [2];
    logic [7:0] data1_v [2];

    logic gnt0_a, gnt1_a, code_a, busy_a, src_a, done_a;
    logic gnt0_b, gnt1_b, code_b, busy_b, src_b, done_b;
    logic [1:0] gnt0_v, gnt1_v, code_v, busy_v, src_v, done_v;

    assign gnt0_v = {gnt0_b, gnt0_a};
    assign gnt1_v = {gnt1_b, gnt1_a};
    assign code_v = {code_b, code_a};
    assign busy_v = {busy_b, busy_a};
    assign src_v  = {src_b, src_a};
    assign done_v = {done_b, done_a};

    always #5 clk_in = ~clk_in;

    man_tx_sched #(.IDLE_LEVEL(IDLE_LEVEL), .GAP_HALVES(GH_A)) dut_a (
        .clk_in(clk_in), .rst(rst), .bit_tick(bit_tick), .en(en_v[0]),
        .req0(req0_v[0]), .data0(data0_v[0]), .req1(req1_v[0]), .data1(data1_v[0]),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .code(code_a), .busy(busy_a), .src(src_a), .tx_done(done_a)
    );

    man_tx_sched #(.IDLE_LEVEL(IDLE_LEVEL), .GAP_HALVES(GH_B)) dut_b (
        .clk_in(clk_in), .rst(rst), .bit_tick(bit_tick), .en(en_v[1]),
        .req0(req0_v[1]), .data0(data0_v[1]), .req1(req1_v[1]), .data1(data1_v[1]),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .code(code_b), .busy(busy_b), .src(src_b), .tx_done(done_b)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int inst, input logic [15:0] act, input logic [15:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s[%0d] got %h expected %h at %0t", nm, inst, act, want, $time);
    endtask

    // Model: a frame is the 17 ticks after its grant, followed by gh ticks of gap.
    logic        m_busy [2];
    logic        m_code [2];
    logic        m_src  [2];
    logic        m_done [2];
    int          m_ticks[2];
    logic [15:0] m_word [2];

    function automatic int gh(input int i);
        return (i == 0) ? GH_A : GH_B;
    endfunction

    function automatic logic [15:0] man_word(input logic [7:0] d);
        logic [15:0] w;
        for (int k = 0; k < 8; k++) begin
            w[15 - 2*k] = ~d[7 - k];
            w[14 - 2*k] =  d[7 - k];
        end
        return w;
    endfunction

    function automatic logic eg0(input int i);
        return rst && !m_busy[i] && en_v[i] && req0_v[i] && (!req1_v[i] || m_src[i]);
    endfunction

    function automatic logic eg1(input int i);
        return rst && !m_busy[i] && en_v[i] && req1_v[i] && (!req0_v[i] || !m_src[i]);
    endfunction

    always @(posedge clk_in) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_busy[i]  <= 1'b0;
                m_code[i]  <= IDLE_LEVEL;
                m_src[i]   <= 1'b1;
                m_done[i]  <= 1'b0;
                m_ticks[i] <= 0;
            end else begin
                m_done[i] <= 1'b0;
                if (!m_busy[i]) begin
                    if (eg0(i) || eg1(i)) begin
                        m_busy[i]  <= 1'b1;
                        m_src[i]   <= eg1(i);
                        m_word[i]  <= man_word(eg1(i) ? data1_v[i] : data0_v[i]);
                        m_ticks[i] <= 0;
                    end
                end else if (bit_tick) begin
                    m_ticks[i] <= m_ticks[i] + 1;
                    if (m_ticks[i] < 16) m_code[i] <= m_word[i][15 - m_ticks[i]];
                    if (m_ticks[i] + 1 == 17) begin
                        m_code[i] <= IDLE_LEVEL;
                        m_done[i] <= 1'b1;
                    end
                    if (m_ticks[i] + 1 == 17 + gh(i)) m_busy[i] <= 1'b0;
                end
            end
        end
    end

    bit chk_on = 1'b0;
    logic g0_seen = 1'b0;
    logic g1_seen = 1'b0;
    int nb_g = 0;
    int nb_d = 0;

    always @(negedge clk_in) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("gnt0", i, 16'(gnt0_v[i]), 16'(eg0(i)));
                chk("gnt1", i, 16'(gnt1_v[i]), 16'(eg1(i)));
                chk("code", i, 16'(code_v[i]), 16'(m_code[i]));
                chk("busy", i, 16'(busy_v[i]), 16'(m_busy[i]));
                chk("src", i, 16'(src_v[i]), 16'(m_src[i]));
                chk("tx_done", i, 16'(done_v[i]), 16'(m_done[i]));
            end
        end
        g0_seen = gnt0_a;
        g1_seen = gnt1_a;
        if (!rst) begin
            nb_g = 0;
            nb_d = 0;
        end else begin
            nb_g = nb_g + int'(gnt0_b);
            nb_d = nb_d + int'(done_b);
        end
    end

    bit rnd_mode = 1'b0;
    int tick_cd = 0;

    always @(posedge clk_in) begin
        #1;
        if (tick_cd == 0) begin
            bit_tick = 1'b1;
            tick_cd = rnd_mode ? int'($urandom_range(1, 4)) : 3;
        end else begin
            bit_tick = 1'b0;
            tick_cd = tick_cd - 1;
        end
    end

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic tick_edge(input string nm);
        bit f;
        f = 1'b0;
        for (int k = 0; k < 20 && !f; k++) begin
            @(posedge clk_in);
            if (bit_tick) f = 1'b1;
        end
        if (!f) chk(nm, 0, 16'd0, 16'd1);
    endtask

    task automatic wait_idle();
        bit f;
        f = 1'b0;
        for (int k = 0; k < 300 && !f; k++) begin
            @(negedge clk_in);
            if (!busy_a) f = 1'b1;
        end
        if (!f) chk("idle_timeout", 0, 16'd0, 16'd1);
        step();
    endtask

    task automatic wait_gnt(input bit one, input string nm);
        bit f;
        f = 1'b0;
        for (int k = 0; k < 400 && !f; k++) begin
            @(negedge clk_in);
            if (one ? gnt1_a : gnt0_a) f = 1'b1;
        end
        chk(nm, 0, 16'(f), 16'd1);
    endtask

    logic [15:0] halves;
    logic        rr_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        data0_v[0] = 8'h00; data0_v[1] = 8'h00;
        data1_v[0] = 8'h00; data1_v[1] = 8'h00;
        @(posedge clk_in);
        chk_on = 1'b1;
        #2;
        repeat (3) step();
        @(negedge clk_in);
        chk("rst_code", 0, 16'(code_a), 16'(IDLE_LEVEL));
        chk("rst_busy", 0, 16'(busy_a), 16'd0);
        chk("rst_src", 0, 16'(src_a), 16'd1);
        chk("rst_tx_done", 0, 16'(done_a), 16'd0);
        chk("rst_gnt0_b", 1, 16'(gnt0_b), 16'd0);
        step();
        rst = 1'b1;

        // A5 frame, halves captured one per tick edge
        req0_v[0] = 1'b1; data0_v[0] = 8'hA5;
        wait_gnt(1'b0, "a5_gnt0");
        step();
        req0_v[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick_edge("a5_tick");
            @(negedge clk_in);
            halves[15 - k] = code_a;
        end
        chk("a5_halves", 0, halves, 16'h6699);
        tick_edge("a5_tick");
        @(negedge clk_in);
        chk("a5_tx_done", 0, 16'(done_a), 16'd1);
        chk("a5_gap_busy", 0, 16'(busy_a), 16'd1);
        tick_edge("a5_tick");
        tick_edge("a5_tick");
        @(negedge clk_in);
        chk("a5_gap_end", 0, 16'(busy_a), 16'd0);
        step();

        // round robin with both requests held from reset
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        req0_v[0] = 1'b1; data0_v[0] = 8'h3C;
        req1_v[0] = 1'b1; data1_v[0] = 8'hC3;
        for (int g = 0; g < 4; g++) begin
            bit f;
            f = 1'b0;
            for (int k = 0; k < 300 && !f; k++) begin
                @(negedge clk_in);
                if (gnt0_a || gnt1_a) f = 1'b1;
            end
            chk("rr_seen", g, 16'(f), 16'd1);
            chk("rr_order", g, 16'(gnt1_a), 16'(rr_exp[g]));
            step();
        end
        req0_v[0] = 1'b0; req1_v[0] = 1'b0;
        wait_idle();

        // grant cycle coinciding with a tick
        for (int k = 0; k < 20 && !bit_tick; k++) step();
        req0_v[0] = 1'b1; data0_v[0] = 8'h5A;
        @(negedge clk_in);
        chk("tick_grant", 0, 16'(gnt0_a), 16'd1);
        step();
        req0_v[0] = 1'b0;
        @(negedge clk_in);
        chk("tick_grant_line", 0, 16'(code_a), 16'(IDLE_LEVEL));
        tick_edge("tg_tick");
        @(negedge clk_in);
        chk("tick_grant_first", 0, 16'(code_a), 16'd1);
        wait_idle();

        // reset at half-bit 7, requester 1 keeps asking
        req1_v[0] = 1'b1; data1_v[0] = 8'h96;
        wait_gnt(1'b1, "mid_gnt1");
        for (int k = 0; k < 8; k++) tick_edge("mid_tick");
        #2;
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk_in);
        chk("mid_code", 0, 16'(code_a), 16'(IDLE_LEVEL));
        chk("mid_no_done", 0, 16'(done_a), 16'd0);
        chk("mid_busy", 0, 16'(busy_a), 16'd0);
        chk("mid_regnt1", 0, 16'(gnt1_a), 16'd1);
        step();
        req1_v[0] = 1'b0;
        wait_idle();

        // enable gating
        en_v[0] = 1'b0;
        req0_v[0] = 1'b1; data0_v[0] = 8'h81;
        repeat (12) step();
        @(negedge clk_in);
        chk("en_block_gnt", 0, 16'(gnt0_a), 16'd0);
        chk("en_block_code", 0, 16'(code_a), 16'(IDLE_LEVEL));
        step();
        en_v[0] = 1'b1;
        @(negedge clk_in);
        chk("en_gnt0", 0, 16'(gnt0_a), 16'd1);
        step();
        req0_v[0] = 1'b0;
        wait_idle();

        // random traffic on instance A, random tick spacing
        rnd_mode = 1'b1;
        repeat (3000) begin
            step();
            if (g0_seen) begin
                if ($urandom_range(0, 1) == 1) data0_v[0] = 8'($urandom);
                else req0_v[0] = 1'b0;
            end else if (req0_v[0] && $urandom_range(0, 31) == 0) begin
                req0_v[0] = 1'b0;
            end else if (!req0_v[0] && $urandom_range(0, 3) == 0) begin
                req0_v[0] = 1'b1;
                data0_v[0] = 8'($urandom);
            end
            if (g1_seen) begin
                if ($urandom_range(0, 1) == 1) data1_v[0] = 8'($urandom);
                else req1_v[0] = 1'b0;
            end else if (req1_v[0] && $urandom_range(0, 31) == 0) begin
                req1_v[0] = 1'b0;
            end else if (!req1_v[0] && $urandom_range(0, 3) == 0) begin
                req1_v[0] = 1'b1;
                data1_v[0] = 8'($urandom);
            end
            en_v[0] = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 499) != 0);
        end
        rst = 1'b1;
        en_v[0] = 1'b1;
        req0_v[0] = 1'b0; req1_v[0] = 1'b0;
        wait_idle();

        // back-to-back frames on the zero-gap instance: one grant per frame
        chk("b_frames_seen", 1, 16'(nb_g > 2), 16'd1);
        chk("b_gnt_per_frame", 1, 16'((nb_g - nb_d) >= 0 && (nb_g - nb_d) <= 1), 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
